spi_shift_ctrl: RTL
===================

SPI_SHIFT_CTRL -- requirements
Module: spi_shift_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8: frame length in bits (2..16).
REQ-002 SHALL have parameter CPOL, default 0: SCLK idle level.
REQ-003 SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port tx_data, input, DATA_W: frame to transmit, MSB first.
REQ-007 SHALL have port tx_valid, input, 1: request a frame.
REQ-008 SHALL have port tx_ready, output, 1: high only in IDLE; a frame is accepted when tx_valid & tx_ready.
REQ-009 SHALL have port baud_start, output, 1: level enable that drives the baud generator's start input.
REQ-010 SHALL have port baud_clk, input, 1: divided clock from the baud generator's clk_out, synchronous to clk.
REQ-011 SHALL have port sclk, output, 1: SPI serial clock.
REQ-012 SHALL have port mosi, output, 1: serial data out.
REQ-013 SHALL have port miso, input, 1: serial data in.
REQ-014 SHALL have port cs_n, output, 1: chip select, active low.
REQ-015 SHALL have port rx_data, output, DATA_W: last received frame, held until the next completion.
REQ-016 SHALL have port rx_valid, output, 1: one-cycle pulse when rx_data updates.
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-018 SHALL use the FSM states IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
REQ-019 IDLE: on accept, SHALL load the tx shift register, clear the bit counter, drop cs_n and enter SETUP on the next cycle.
REQ-020 SETUP: SHALL last exactly 1 cycle, drive mosi = tx_data[DATA_W-1] and raise baud_start, then enter SHIFT.
REQ-021 baud_start SHALL be high in SETUP and SHIFT and low in all other states.
REQ-022 SHALL register baud_clk into baud_q; lead edge = baud_clk & ~baud_q, trail edge = ~baud_clk & baud_q; edges SHALL be ignored outside SHIFT.
REQ-023 sclk SHALL equal CPOL in every state except SHIFT; in SHIFT it SHALL toggle on each lead and trail edge, one cycle after the edge is detected.
REQ-024 CPHA=0: SHALL sample miso into the rx shift register on lead edges and shift mosi to the next bit on trail edges.
REQ-025 CPHA=1: SHALL shift mosi on lead edges (first lead edge presents bit DATA_W-1) and sample miso on trail edges.
REQ-026 The bit counter SHALL increment per sample; when a trail edge occurs with count == DATA_W, the FSM SHALL enter HOLD.
REQ-027 HOLD: SHALL last 1 cycle with cs_n high and sclk = CPOL, and SHALL write rx_data and pulse rx_valid on that cycle.
REQ-028 Back-to-back frames: tx_ready SHALL rise the cycle after HOLD; minimum cs_n high time is 2 cycles.
REQ-029 tx_valid while busy SHALL be ignored, with no queuing.
REQ-030 mosi SHALL be 0 in IDLE and HOLD.
REQ-031 The counter SHALL be $clog2(DATA_W+1) bits wide, with no wrap within a frame.

Reset
REQ-032 When rst is high at a clk edge, the block SHALL go to IDLE, set cs_n=1, sclk=CPOL, mosi=0, baud_start=0, rx_data=0, rx_valid=0, busy=0, tx_ready=1 on the following cycle, and clear the shift registers, counter and baud_q.
REQ-033 A reset mid-frame SHALL abort the frame without an rx_valid pulse; rst SHALL override a simultaneous accept.

Structure
REQ-034 The state encoding (IDLE, SETUP, SHIFT, HOLD) SHALL live in shared package spi_pkg alongside the SPI mode constants.
REQ-035 The edge detector SHALL be a separate sub-module named spi_edge_det (in: clk, rst, sig, en; out: rise, fall); all other logic SHALL stay flat.

Verification
REQ-036 With CPOL=0, CPHA=0, DATA_W=8, psc=4, miso looped to mosi, tx 0xA5: a single rx_valid, rx_data=0xA5, and exactly 8 sclk rising edges while cs_n is low.
REQ-037 With miso tied 1, tx 0x00: rx_data=0xFF; mosi low throughout.
REQ-038 With tx_valid held high and data 0x3C then 0xC3: two frames, cs_n high for 2 cycles between them, rx 0x3C then 0xC3 in loopback.
REQ-039 With rst asserted after the 4th sample edge: next cycle cs_n=1, baud_start=0, no rx_valid; a new frame of 0x81 then completes correctly.
REQ-040 With CPOL=1, CPHA=1, loopback, tx 0x5A: sclk idles high, 8 trail (rising) sample edges, rx_data=0x5A.
REQ-041 A tx_valid pulse mid-frame with 0xFF SHALL be ignored: the current frame completes unchanged and no second frame starts.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI controller state encoding and SPI mode constants
package spi_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  localparam logic [1:0] SPI_MODE0 = 2'd0;
  localparam logic [1:0] SPI_MODE1 = 2'd1;
  localparam logic [1:0] SPI_MODE2 = 2'd2;
  localparam logic [1:0] SPI_MODE3 = 2'd3;
  function automatic logic mode_cpol(input logic [1:0] m);
    return m[1];
  endfunction
  function automatic logic mode_cpha(input logic [1:0] m);
    return m[0];
  endfunction
endpackage

// File: rtl/spi_edge_det.sv
// spi_edge_det: registered-history edge detector, edges qualified by en
module spi_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  input  logic en,
  output logic rise,
  output logic fall
);
  logic q;
  always_ff @(posedge clk) q <= rst ? 1'b0 : sig;
  assign rise = en & sig & ~q;
  assign fall = en & ~sig & q;
endmodule

// File: rtl/spi_shift_ctrl.sv
// spi_shift_ctrl: SPI master frame controller paced by an external baud generator
module spi_shift_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter bit CPOL   = 1'b0,
  parameter bit CPHA   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              baud_start,
  input  logic              baud_clk,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W + 1);
  state_t            state;
  logic [DATA_W-1:0] tx_sr, rx_sr, rx_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              lead, trail, samp, shft, done, shift_en;
  assign shift_en = state == SHIFT;
  spi_edge_det u_edge (
    .clk (clk),
    .rst (rst),
    .sig (baud_clk),
    .en  (shift_en),
    .rise(lead),
    .fall(trail)
  );
  // with CPHA=1 the first lead edge re-presents the MSB instead of shifting
  assign samp    = CPHA ? trail : lead;
  assign shft    = CPHA ? lead & (cnt != '0) : trail;
  assign cnt_nxt = cnt + CW'(samp);
  assign rx_nxt  = samp ? {rx_sr[DATA_W-2:0], miso} : rx_sr;
  assign done    = trail && cnt_nxt == CW'(DATA_W);
  assign tx_ready   = state == IDLE;
  assign busy       = state != IDLE;
  assign baud_start = state == SETUP || state == SHIFT;
  assign mosi       = baud_start & tx_sr[DATA_W-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cs_n     <= 1'b1;
      sclk     <= CPOL;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      cnt      <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: if (tx_valid) begin
          tx_sr <= tx_data;
          rx_sr <= '0;
          cnt   <= '0;
          cs_n  <= 1'b0;
          state <= SETUP;
        end
        SETUP: state <= SHIFT;
        SHIFT: begin
          if (lead | trail) sclk <= ~sclk;
          if (shft) tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
          cnt   <= cnt_nxt;
          rx_sr <= rx_nxt;
          if (done) begin
            state    <= HOLD;
            cs_n     <= 1'b1;
            sclk     <= CPOL;
            rx_data  <= rx_nxt;
            rx_valid <= 1'b1;
          end
        end
        HOLD: state <= IDLE;
      endcase
    end
  end
endmodule
